mem_arbiter: RTL and testbench

Two-requester arbiter sharing a single-ported synchronous word memory between the instruction-fetch port and the data (load/store) port of the pipelined processor. Grants at most one access per cycle, drives the memory's enable/write/address/data lines, and routes the one-cycle-late read data back to the requester that issued the read. Data port has fixed priority; an optional starvation guard bounds instruction-fetch wait time. Sits between the pipeline's fetch/memory stages and the shared memory array.

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one single-ported synchronous word memory between the
// instruction-fetch port (i_*) and the data load/store port (d_*).
//
// At most one access is granted per cycle. The data port has fixed priority.
// Read data returns from the memory one cycle after issue, and is routed to
// the port that issued the read using a registered owner flag.
//
// Optional feature: define MEM_ARB_STARVE_EN to enable the starvation guard.
// With the guard, an instruction request that has been denied STARVE_LIMIT
// consecutive cycles is granted ahead of the data port. Without the macro,
// priority is strictly data-first.
//
// Ports:
//   CLK, RST                 clock; synchronous active-low reset
//   i_req/i_addr/i_ready     instruction read request, byte address, accept
//   i_rvalid/i_rdata         instruction read response (one cycle after accept)
//   d_req/d_we/d_addr/d_wdata  data request (write when d_we=1)
//   d_ready                  data accept
//   d_rvalid/d_rdata         data read response (one cycle after accept)
//   m_en/m_we/m_addr/m_wdata memory command (word address = byte addr[AW-1:2])
//   m_rdata                  memory read data, valid the cycle after a read
module mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ready,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-3:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    owner_e owner_q, owner_d;
    logic   gnt_i, gnt_d;
    logic   force_i;

`ifdef MEM_ARB_STARVE_EN
    logic [3:0] starve_cnt_q, starve_cnt_d;

    // An instruction request that has waited the full limit takes this slot.
    assign force_i = i_req && (starve_cnt_q == LIMIT);

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!i_req || gnt_i)
            starve_cnt_d = 4'd0;
        else if (starve_cnt_q != LIMIT)
            starve_cnt_d = starve_cnt_q + 4'd1;
    end

    always_ff @(posedge CLK) begin
        if (!RST)
            starve_cnt_q <= 4'd0;
        else
            starve_cnt_q <= starve_cnt_d;
    end
`else
    assign force_i = 1'b0;

    logic unused_limit;
    assign unused_limit = ^LIMIT;
`endif

    // Byte-offset bits never reach the word-addressed memory.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{i_addr[1:0], d_addr[1:0]};

    // Grant: nothing while in reset, data first unless the guard forces fetch.
    always_comb begin
        gnt_d = RST && d_req && !force_i;
        gnt_i = RST && i_req && !gnt_d;
    end

    always_comb begin
        i_ready = gnt_i;
        d_ready = gnt_d;
        m_en    = gnt_i || gnt_d;
        m_we    = gnt_d && d_we;
        m_addr  = '0;
        m_wdata = '0;
        if (gnt_d)
            m_addr = d_addr[AW-1:2];
        else if (gnt_i)
            m_addr = i_addr[AW-1:2];
        if (gnt_i || gnt_d)
            m_wdata = d_wdata;
    end

    // Remember who issued a read so next cycle's m_rdata goes to them.
    always_comb begin
        owner_d = OWN_NONE;
        if (gnt_i)
            owner_d = OWN_INST;
        else if (gnt_d && !d_we)
            owner_d = OWN_DATA;
    end

    always_ff @(posedge CLK) begin
        if (!RST)
            owner_q <= OWN_NONE;
        else
            owner_q <= owner_d;
    end

    // Responses are masked while reset is asserted so a read issued just
    // before reset never shows up as valid.
    always_comb begin
        i_rvalid = RST && (owner_q == OWN_INST);
        d_rvalid = RST && (owner_q == OWN_DATA);
        i_rdata  = i_rvalid ? m_rdata : '0;
        d_rdata  = d_rvalid ? m_rdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;
`ifdef MEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0, m_rdata = '0;
    logic          i_ready, i_rvalid, d_ready, d_rvalid, m_en, m_we;
    logic [DW-1:0] i_rdata, d_rdata, m_wdata;
    logic [AW-3:0] m_addr;

    always #5 CLK = ~CLK;

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
        .CLK(CLK), .RST(RST),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Memory device driven by the DUT, and an independent shadow image the
    // reference model reads and writes from the request side.
    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];

    // Reference model: who gets the pending response, its data, and how long
    // the fetch port has been waiting.
    int            ref_owner = 0;  // 0 none, 1 inst, 2 data
    logic [DW-1:0] ref_rdata = '0;
    int            ref_wait  = 0;
    bit            e_gi = 1'b0, e_gd = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        bit            force_i;
        logic [AW-3:0] exp_addr;
        @(negedge CLK);
        force_i = STARVE_EN && i_req && (ref_wait == LIM);
        e_gd = RST && d_req && !force_i;
        e_gi = RST && i_req && !e_gd;
        exp_addr = e_gd ? d_addr[AW-1:2] : (e_gi ? i_addr[AW-1:2] : '0);
        chk("i_ready", 64'(i_ready), 64'(e_gi));
        chk("d_ready", 64'(d_ready), 64'(e_gd));
        chk("m_en", 64'(m_en), 64'(e_gi || e_gd));
        chk("m_we", 64'(m_we), 64'(e_gd && d_we));
        chk("m_addr", 64'(m_addr), 64'(exp_addr));
        chk("m_wdata", 64'(m_wdata), 64'((e_gi || e_gd) ? d_wdata : '0));
        chk("i_rvalid", 64'(i_rvalid), 64'(RST && ref_owner == 1));
        chk("d_rvalid", 64'(d_rvalid), 64'(RST && ref_owner == 2));
        chk("i_rdata", 64'(i_rdata), 64'((RST && ref_owner == 1) ? ref_rdata : '0));
        chk("d_rdata", 64'(d_rdata), 64'((RST && ref_owner == 2) ? ref_rdata : '0));
    endtask

    task automatic advance();
        logic          en, we;
        logic [AW-3:0] a;
        logic [DW-1:0] wd;
        if (!RST) begin
            ref_owner = 0;
            ref_wait  = 0;
        end else begin
            ref_owner = 0;
            if (e_gi) begin
                ref_owner = 1;
                ref_rdata = ref_mem[i_addr[9:2]];
            end else if (e_gd) begin
                if (d_we) ref_mem[d_addr[9:2]] = d_wdata;
                else begin
                    ref_owner = 2;
                    ref_rdata = ref_mem[d_addr[9:2]];
                end
            end
            if (!i_req || e_gi) ref_wait = 0;
            else if (ref_wait < LIM) ref_wait++;
        end
        en = m_en; we = m_we; a = m_addr; wd = m_wdata;
        @(posedge CLK);
        // Idle cycles put garbage on m_rdata so ungated rdata is visible.
        if (en && we) mem[a[7:0]] = wd;
        else if (en) m_rdata = mem[a[7:0]];
        else m_rdata = $urandom;
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            mem[k] = $urandom;
            ref_mem[k] = mem[k];
        end
        mem[4] = 32'h2002_0005;
        ref_mem[4] = 32'h2002_0005;

        // Reset held with both requests up.
        RST = 1'b0; i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("rst_i_ready", 64'(i_ready), 64'(0));
            chk("rst_d_ready", 64'(d_ready), 64'(0));
            chk("rst_m_en", 64'(m_en), 64'(0));
            chk("rst_rvalid", 64'({i_rvalid, d_rvalid}), 64'(0));
            advance();
        end
        RST = 1'b1;
        sample();
        chk("post_rst_d_ready", 64'(d_ready), 64'(1));
        advance();
        i_req = 1'b0; d_req = 1'b0;
        step();

        // Instruction read of word 4.
        i_req = 1'b1; i_addr = 32'h0000_0010;
        sample();
        chk("ird_m_addr", 64'(m_addr), 64'(4));
        chk("ird_m_we", 64'(m_we), 64'(0));
        advance();
        i_req = 1'b0;
        sample();
        chk("ird_i_rvalid", 64'(i_rvalid), 64'(1));
        chk("ird_i_rdata", 64'(i_rdata), 64'(32'h2002_0005));
        chk("ird_d_rvalid", 64'(d_rvalid), 64'(0));
        advance();

        // Data write then read back.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
        sample();
        chk("dwr_m_we", 64'(m_we), 64'(1));
        chk("dwr_m_addr", 64'(m_addr), 64'(8));
        advance();
        d_we = 1'b0;
        sample();
        chk("dwr_no_rvalid", 64'({i_rvalid, d_rvalid}), 64'(0));
        advance();
        d_req = 1'b0;
        sample();
        chk("drd_d_rvalid", 64'(d_rvalid), 64'(1));
        chk("drd_d_rdata", 64'(d_rdata), 64'(32'hDEAD_BEEF));
        advance();

        // Contention: data first, then instruction; responses in order.
        i_req = 1'b1; i_addr = 32'h40; d_req = 1'b1; d_addr = 32'h30;
        sample();
        chk("cont_d_ready", 64'(d_ready), 64'(1));
        chk("cont_i_ready", 64'(i_ready), 64'(0));
        advance();
        d_req = 1'b0;
        sample();
        chk("cont_i_ready2", 64'(i_ready), 64'(1));
        chk("cont_d_resp", 64'(d_rvalid), 64'(1));
        advance();
        i_req = 1'b0;
        sample();
        chk("cont_i_resp", 64'(i_rvalid), 64'(1));
        advance();

        // Continuous contention: fetch gets every fifth slot only with the guard.
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sample();
            chk("starve_d_ready", 64'(d_ready), 64'(!STARVE_EN || (k % 5 != 4)));
            chk("starve_i_ready", 64'(i_ready), 64'(STARVE_EN && (k % 5 == 4)));
            advance();
        end

        // Dropping i_req clears the wait count: four more data grants follow.
        i_req = 1'b0;
        step();
        i_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sample();
            chk("drop_d_ready", 64'(d_ready), 64'(1));
            advance();
        end
        i_req = 1'b0; d_req = 1'b0;
        step();

        // Reset right after a data read issue: no response appears.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        step();
        RST = 1'b0; d_req = 1'b0;
        sample();
        chk("rstmid_rvalid", 64'(d_rvalid), 64'(0));
        advance();
        RST = 1'b1;
        sample();
        chk("rstmid_rvalid2", 64'(d_rvalid), 64'(0));
        advance();

        // Random traffic; an unaccepted request usually stays put.
        for (int k = 0; k < 400; k++) begin
            if (!(i_req && !e_gi) || $urandom_range(0, 9) == 0) begin
                i_req  = ($urandom_range(0, 3) != 0);
                i_addr = 32'($urandom_range(0, 1023));
            end
            if (!(d_req && !e_gd) || $urandom_range(0, 9) == 0) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = ($urandom_range(0, 2) == 0);
                d_addr  = 32'($urandom_range(0, 1023));
                d_wdata = $urandom;
            end
            RST = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
